piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 141 ++++++++++++++
 tb/tb_piso_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter with valid/ready load handshake.
// One word is shifted out one bit per cycle, MSB or LSB first, with a
// registered serial output. A new word can be accepted on the last bit of a
// frame, so consecutive frames stream without an idle gap.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits of every frame.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  // Counter holds the number of bits still to come after the one on data_out.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count_reg;
  logic             data_out_reg;
  logic             valid_reg;
  logic             done_reg;
  logic             ready_reg;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_shift;
  logic [WIDTH-1:0] shift_next;

  // ready_reg is the registered "can take a word" state; rst gates it so no
  // load can be accepted in a reset cycle.
  assign load_ready = ready_reg & ~rst;
  assign accept     = load_valid & load_ready;

  // The shift register always holds the bits remaining after the one that is
  // currently on data_out, aligned so the next bit sits at the output end.
  assign first_bit  = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
  assign load_shift = (MSB_FIRST != 0) ? {data_in[WIDTH-2:0], 1'b0}
                                       : {1'b0, data_in[WIDTH-1:1]};
  assign next_bit   = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
  assign shift_next = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                       : {1'b0, shift_reg[WIDTH-1:1]};

  assign data_out   = data_out_reg;
  assign data_valid = valid_reg;
  assign busy       = valid_reg;
  assign done       = done_reg;

  // Frame sequencer: load, shift, optional parity, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      count_reg    <= '0;
      data_out_reg <= 1'b0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        // Accepted either from IDLE or on the last bit of the previous frame.
        state_reg    <= SHIFT;
        shift_reg    <= load_shift;
        count_reg    <= CW'(WIDTH - 1);
        data_out_reg <= first_bit;
        valid_reg    <= 1'b1;
        ready_reg    <= 1'b0;
`ifdef PISO_PARITY_EN
        parity_reg   <= ^data_in;
`endif
      end else begin
        case (state_reg)
          SHIFT: begin
            if (count_reg != '0) begin
              data_out_reg <= next_bit;
              shift_reg    <= shift_next;
              count_reg    <= count_reg - CW'(1);
`ifndef PISO_PARITY_EN
              // Entering the final data bit: it ends the frame.
              if (count_reg == CW'(1)) begin
                done_reg  <= 1'b1;
                ready_reg <= 1'b1;
              end
`endif
            end else begin
`ifdef PISO_PARITY_EN
              // Last data bit done; parity bit closes the frame.
              state_reg    <= PARITY;
              data_out_reg <= parity_reg;
              done_reg     <= 1'b1;
              ready_reg    <= 1'b1;
`else
              state_reg    <= IDLE;
              data_out_reg <= 1'b0;
              valid_reg    <= 1'b0;
              ready_reg    <= 1'b1;
`endif
            end
          end
`ifdef PISO_PARITY_EN
          PARITY: begin
            state_reg    <= IDLE;
            data_out_reg <= 1'b0;
            valid_reg    <= 1'b0;
            ready_reg    <= 1'b1;
          end
`endif
          default: begin
            state_reg    <= IDLE;
            data_out_reg <= 1'b0;
            valid_reg    <= 1'b0;
            ready_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx (WIDTH=4), one MSB-first and one
// LSB-first instance. Expected serial bits are queued when a word is offered
// and popped by per-instance monitors whenever data_valid is high.
// Honours PISO_PARITY_EN the same way as the design.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in_m, data_in_l;
  logic       load_valid_m, load_valid_l;
  logic       load_ready_m, load_ready_l;
  logic       data_out_m, data_out_l;
  logic       data_valid_m, data_valid_l;
  logic       busy_m, busy_l;
  logic       done_m, done_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] sipo;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in_m), .load_valid(load_valid_m),
    .load_ready(load_ready_m), .data_out(data_out_m), .data_valid(data_valid_m),
    .busy(busy_m), .done(done_m)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in_l), .load_valid(load_valid_l),
    .load_ready(load_ready_l), .data_out(data_out_l), .data_valid(data_valid_l),
    .busy(busy_l), .done(done_l)
  );

  // Queue the first 'keep' bits of a frame for word w; done marks the frame end.
  function automatic void push_frame(input logic [3:0] w, input bit msb,
                                     input int keep, input bit to_l);
    exp_t e;
    for (int i = 0; i < FRAME && i < keep; i++) begin
      if (i < 4) e.b = msb ? w[3-i] : w[i];
      else       e.b = ^w;
      e.d = (i == FRAME - 1);
      if (to_l) q_l.push_back(e);
      else      q_m.push_back(e);
    end
  endfunction

  // Scoreboard check of the MSB-first instance.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    assert (busy_m === data_valid_m) else begin
      failures++;
      $error("FAIL m_busy busy=%0b required=%0b", busy_m, data_valid_m);
    end
    checks++;
    if (data_valid_m === 1'b1) begin
      if (q_m.size() == 0) begin
        failures++;
        $error("FAIL m_extra_bit data_out=%0b required=no_valid_bit", data_out_m);
      end else begin
        e = q_m.pop_front();
        assert ({data_out_m, done_m} === {e.b, e.d}) else begin
          failures++;
          $error("FAIL m_bit out/done=%0b/%0b required=%0b/%0b",
                 data_out_m, done_m, e.b, e.d);
        end
      end
    end else begin
      assert ({data_out_m, done_m, data_valid_m} === 3'b000) else begin
        failures++;
        $error("FAIL m_idle out/done/valid=%0b/%0b/%0b required=0/0/0",
               data_out_m, done_m, data_valid_m);
      end
    end
  end

  // Scoreboard check of the LSB-first instance.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    assert (busy_l === data_valid_l) else begin
      failures++;
      $error("FAIL l_busy busy=%0b required=%0b", busy_l, data_valid_l);
    end
    checks++;
    if (data_valid_l === 1'b1) begin
      if (q_l.size() == 0) begin
        failures++;
        $error("FAIL l_extra_bit data_out=%0b required=no_valid_bit", data_out_l);
      end else begin
        e = q_l.pop_front();
        assert ({data_out_l, done_l} === {e.b, e.d}) else begin
          failures++;
          $error("FAIL l_bit out/done=%0b/%0b required=%0b/%0b",
                 data_out_l, done_l, e.b, e.d);
        end
      end
    end else begin
      assert ({data_out_l, done_l, data_valid_l} === 3'b000) else begin
        failures++;
        $error("FAIL l_idle out/done/valid=%0b/%0b/%0b required=0/0/0",
               data_out_l, done_l, data_valid_l);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  // Offer one word at a negedge; it is accepted on the following posedge.
  // Returns at the negedge where the first bit is visible.
  task automatic send_m(input logic [3:0] w);
    chk("m_ready_before_load", {7'd0, load_ready_m}, 8'd1);
    load_valid_m = 1'b1;
    data_in_m    = w;
    @(negedge clk);
    load_valid_m = 1'b0;
  endtask

  task automatic send_l(input logic [3:0] w);
    chk("l_ready_before_load", {7'd0, load_ready_l}, 8'd1);
    load_valid_l = 1'b1;
    data_in_l    = w;
    @(negedge clk);
    load_valid_l = 1'b0;
  endtask

  initial begin
    // Reset with a word offered on both instances: nothing may be accepted.
    rst = 1'b1;
    load_valid_m = 1'b1; data_in_m = 4'b1111;
    load_valid_l = 1'b1; data_in_l = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_ready_low", {6'd0, load_ready_m, load_ready_l}, 8'd0);
    chk("rst_outputs", {5'd0, data_out_m, data_valid_m, done_m}, 8'd0);
    rst = 1'b0;
    load_valid_m = 1'b0;
    load_valid_l = 1'b0;
    #1;
    chk("ready_after_release", {6'd0, load_ready_m, load_ready_l}, 8'd3);
    @(negedge clk);
    $display("txn reset: done");

    // Single word 1011, MSB first, captured by a 4-bit downstream sipo model.
    push_frame(4'b1011, 1'b1, FRAME, 1'b0);
    send_m(4'b1011);
    sipo = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      sipo = {sipo[2:0], data_out_m};
    end
    chk("sipo_after_4_bits", {4'd0, sipo}, 8'h0b);
    repeat (FRAME - 3) @(negedge clk);
    chk("single_back_to_idle", {6'd0, data_valid_m, load_ready_m}, 8'd1);
    chk("single_queue_drained", 8'(q_m.size()), 8'd0);
    $display("txn single 1011: sipo=%b", sipo);

    // Back-to-back: load_valid held across two words.
    push_frame(4'b1011, 1'b1, FRAME, 1'b0);
    push_frame(4'b0110, 1'b1, FRAME, 1'b0);
    load_valid_m = 1'b1;
    data_in_m    = 4'b1011;
    @(negedge clk);
    data_in_m    = 4'b0110;
    chk("b2b_valid_0", {7'd0, data_valid_m}, 8'd1);
    for (int i = 1; i < 2 * FRAME; i++) begin
      @(negedge clk);
      chk("b2b_gapless_valid", {7'd0, data_valid_m}, 8'd1);
      if (i == FRAME - 1) chk("b2b_ready_last_bit", {7'd0, load_ready_m}, 8'd1);
      if (i == FRAME) load_valid_m = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_idle", {7'd0, data_valid_m}, 8'd0);
    chk("b2b_queue_drained", 8'(q_m.size()), 8'd0);
    $display("txn back-to-back 1011,0110: done");

    // Busy ignore on the LSB-first instance.
    push_frame(4'b0001, 1'b0, FRAME, 1'b1);
    send_l(4'b0001);
    @(negedge clk);
    chk("ignore_ready_low", {7'd0, load_ready_l}, 8'd0);
    load_valid_l = 1'b1;
    data_in_l    = 4'b1111;
    @(negedge clk);
    load_valid_l = 1'b0;
    repeat (FRAME + 1) @(negedge clk);
    chk("ignore_queue_drained", 8'(q_l.size()), 8'd0);
    chk("ignore_idle", {6'd0, data_valid_l, load_ready_l}, 8'd1);
    $display("txn busy-ignore 0001 (1111 offered mid-frame): done");

    // Mid-frame reset after 2 bits of 1011, then a clean 0101.
    push_frame(4'b1011, 1'b1, 2, 1'b0);
    send_m(4'b1011);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {5'd0, data_valid_m, done_m, load_ready_m}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_residual", {7'd0, data_valid_m}, 8'd0);
    push_frame(4'b0101, 1'b1, FRAME, 1'b0);
    send_m(4'b0101);
    repeat (FRAME + 1) @(negedge clk);
    chk("midrst_queue_drained", 8'(q_m.size()), 8'd0);
    chk("midrst_idle", {6'd0, data_valid_m, load_ready_m}, 8'd1);
    $display("txn mid-frame reset then 0101: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
